// File: rtl/legv8_isa_pkg.sv
// legv8_isa_pkg: op enum, opcodes, field positions and immediate ranges for the LEGv8 encoder.
package legv8_isa_pkg;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_AND, OP_ORR, OP_EOR, OP_ANDS, OP_LSR, OP_LSL, OP_BR,
    OP_ADDI, OP_SUBI, OP_ADDIS, OP_SUBIS, OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS,
    OP_STUR, OP_LDUR, OP_MOVZ, OP_MOVK, OP_CBZ, OP_CBNZ, OP_BCOND, OP_B, OP_BL, OP_LDI64
  } op_e;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_D, FMT_IW, FMT_CB, FMT_B, FMT_BAD} fmt_e;
  typedef enum logic {IDLE, EXPAND} state_e;
  localparam logic [10:0] OPC_ADD   = 11'b10001011000;
  localparam logic [10:0] OPC_SUB   = 11'b11001011000;
  localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
  localparam logic [10:0] OPC_AND   = 11'b10001010000;
  localparam logic [10:0] OPC_ORR   = 11'b10101010000;
  localparam logic [10:0] OPC_EOR   = 11'b11001010000;
  localparam logic [10:0] OPC_ANDS  = 11'b11101010000;
  localparam logic [10:0] OPC_LSR   = 11'b11010011010;
  localparam logic [10:0] OPC_LSL   = 11'b11010011011;
  localparam logic [10:0] OPC_BR    = 11'b11010110000;
  localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OPC_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OPC_SUBIS = 10'b1111000100;
  localparam logic [9:0]  OPC_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OPC_ORRI  = 10'b1011001000;
  localparam logic [9:0]  OPC_EORI  = 10'b1101001000;
  localparam logic [9:0]  OPC_ANDIS = 10'b1111001000;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OPC_MOVK  = 9'b111100101;
  localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OPC_BCOND = 8'b01010100;
  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [5:0]  OPC_BL    = 6'b100101;
  localparam int R_OPC_LSB  = 21;
  localparam int I_OPC_LSB  = 22;
  localparam int IW_OPC_LSB = 23;
  localparam int CB_OPC_LSB = 24;
  localparam int B_OPC_LSB  = 26;
  localparam int RM_LSB     = 16;
  localparam int SHAMT_LSB  = 10;
  localparam int IMM12_LSB  = 10;
  localparam int ADDR9_LSB  = 12;
  localparam int HW_LSB     = 21;
  localparam int IMM16_LSB  = 5;
  localparam int ADDR19_LSB = 5;
  localparam int RN_LSB     = 5;
  localparam int RD_LSB     = 0;
  localparam int SHAMT_W    = 6;
  localparam int IMM12_W    = 12;
  localparam int ADDR9_W    = 9;
  localparam int IMM16_W    = 16;
  localparam int ADDR19_W   = 19;
  localparam int ADDR26_W   = 26;
  function automatic logic fits_u(input logic [63:0] v, input int w);
    return (v >> w) == '0;
  endfunction
  // a signed value fits when everything from the field's sign bit up is a pure sign extension
  function automatic logic fits_s(input logic [63:0] v, input int w);
    logic [63:0] t;
    t = 64'($signed(v) >>> (w - 1));
    return t == '0 || t == '1;
  endfunction
  function automatic fmt_e fmt_of(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_AND, OP_ORR, OP_EOR, OP_ANDS, OP_LSR, OP_LSL, OP_BR:
        return FMT_R;
      OP_ADDI, OP_SUBI, OP_ADDIS, OP_SUBIS, OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS:
        return FMT_I;
      OP_STUR, OP_LDUR: return FMT_D;
      OP_MOVZ, OP_MOVK: return FMT_IW;
      OP_CBZ, OP_CBNZ, OP_BCOND: return FMT_CB;
      OP_B, OP_BL: return FMT_B;
      default: return FMT_BAD;
    endcase
  endfunction
  function automatic logic [31:0] opc_word(input logic [4:0] op);
    case (op)
      OP_ADD:   return 32'(OPC_ADD) << R_OPC_LSB;
      OP_SUB:   return 32'(OPC_SUB) << R_OPC_LSB;
      OP_ADDS:  return 32'(OPC_ADDS) << R_OPC_LSB;
      OP_SUBS:  return 32'(OPC_SUBS) << R_OPC_LSB;
      OP_AND:   return 32'(OPC_AND) << R_OPC_LSB;
      OP_ORR:   return 32'(OPC_ORR) << R_OPC_LSB;
      OP_EOR:   return 32'(OPC_EOR) << R_OPC_LSB;
      OP_ANDS:  return 32'(OPC_ANDS) << R_OPC_LSB;
      OP_LSR:   return 32'(OPC_LSR) << R_OPC_LSB;
      OP_LSL:   return 32'(OPC_LSL) << R_OPC_LSB;
      OP_BR:    return 32'(OPC_BR) << R_OPC_LSB;
      OP_ADDI:  return 32'(OPC_ADDI) << I_OPC_LSB;
      OP_SUBI:  return 32'(OPC_SUBI) << I_OPC_LSB;
      OP_ADDIS: return 32'(OPC_ADDIS) << I_OPC_LSB;
      OP_SUBIS: return 32'(OPC_SUBIS) << I_OPC_LSB;
      OP_ANDI:  return 32'(OPC_ANDI) << I_OPC_LSB;
      OP_ORRI:  return 32'(OPC_ORRI) << I_OPC_LSB;
      OP_EORI:  return 32'(OPC_EORI) << I_OPC_LSB;
      OP_ANDIS: return 32'(OPC_ANDIS) << I_OPC_LSB;
      OP_STUR:  return 32'(OPC_STUR) << R_OPC_LSB;
      OP_LDUR:  return 32'(OPC_LDUR) << R_OPC_LSB;
      OP_MOVZ:  return 32'(OPC_MOVZ) << IW_OPC_LSB;
      OP_MOVK:  return 32'(OPC_MOVK) << IW_OPC_LSB;
      OP_CBZ:   return 32'(OPC_CBZ) << CB_OPC_LSB;
      OP_CBNZ:  return 32'(OPC_CBNZ) << CB_OPC_LSB;
      OP_BCOND: return 32'(OPC_BCOND) << CB_OPC_LSB;
      OP_B:     return 32'(OPC_B) << B_OPC_LSB;
      OP_BL:    return 32'(OPC_BL) << B_OPC_LSB;
      default:  return '0;
    endcase
  endfunction
endpackage

// File: rtl/legv8_instr_pack.sv
// legv8_instr_pack: combinational field packer and immediate range check for one LEGv8 instruction.
module legv8_instr_pack
  import legv8_isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [63:0] imm,
  input  logic [1:0]  hw,
  output logic [31:0] instr,
  output logic        err
);
  logic shift, br;
  assign shift = op == OP_LSL || op == OP_LSR;
  assign br = op == OP_BR;
  always_comb begin
    instr = opc_word(op);
    err = 1'b0;
    case (fmt_of(op))
      FMT_R: begin
        instr[RM_LSB +: 5] = br ? 5'd0 : rm;
        instr[SHAMT_LSB +: SHAMT_W] = shift ? imm[SHAMT_W-1:0] : '0;
        instr[RN_LSB +: 5] = rn;
        instr[RD_LSB +: 5] = br ? 5'd0 : rd;
        err = shift && !fits_u(imm, SHAMT_W);
      end
      FMT_I: begin
        instr[IMM12_LSB +: IMM12_W] = imm[IMM12_W-1:0];
        instr[RN_LSB +: 5] = rn;
        instr[RD_LSB +: 5] = rd;
        err = !fits_u(imm, IMM12_W);
      end
      FMT_D: begin
        instr[ADDR9_LSB +: ADDR9_W] = imm[ADDR9_W-1:0];
        instr[RN_LSB +: 5] = rn;
        instr[RD_LSB +: 5] = rd;
        err = !fits_s(imm, ADDR9_W);
      end
      FMT_IW: begin
        instr[HW_LSB +: 2] = hw;
        instr[IMM16_LSB +: IMM16_W] = imm[IMM16_W-1:0];
        instr[RD_LSB +: 5] = rd;
        err = !fits_u(imm, IMM16_W);
      end
      FMT_CB: begin
        instr[ADDR19_LSB +: ADDR19_W] = imm[ADDR19_W-1:0];
        instr[RD_LSB +: 5] = rd;
        err = !fits_s(imm, ADDR19_W);
      end
      FMT_B: begin
        instr[ADDR26_W-1:0] = imm[ADDR26_W-1:0];
        err = !fits_s(imm, ADDR26_W);
      end
      default: begin
        instr = '0;
        err = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: symbolic command to LEGv8 word encoder with LDI64 -> MOVZ/MOVK expansion.
module legv8_instr_encoder
  import legv8_isa_pkg::*;
#(
  parameter bit SKIP_ZERO_HW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rm,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_error
);
  state_e       state;
  logic [3:1]   mask, mask_next, mask_load;
  logic [63:16] imm_q;
  logic [4:0]   rd_q, p_op, p_rd;
  logic [63:0]  p_imm;
  logic [1:0]   k, p_hw;
  logic [15:0]  hw_imm;
  logic [31:0]  p_instr;
  logic         p_err, is_ldi, expand;
  assign expand = state == EXPAND;
  assign is_ldi = in_op == OP_LDI64;
  assign in_ready = !expand && (!out_valid || out_ready);
  // next MOVK targets the lowest halfword still pending in the mask
  assign k = mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
  assign hw_imm = mask[1] ? imm_q[31:16] : mask[2] ? imm_q[47:32] : imm_q[63:48];
  assign mask_next = mask & (mask - 3'd1);
  assign mask_load = SKIP_ZERO_HW ? {in_imm[63:48] != '0, in_imm[47:32] != '0, in_imm[31:16] != '0} : 3'b111;
  assign p_op = expand ? OP_MOVK : is_ldi ? OP_MOVZ : in_op;
  assign p_rd = expand ? rd_q : in_rd;
  assign p_hw = expand ? k : is_ldi ? 2'd0 : in_rm[1:0];
  assign p_imm = expand ? {48'd0, hw_imm} : is_ldi ? {48'd0, in_imm[15:0]} : in_imm;
  legv8_instr_pack u_pack (
    .op(p_op),
    .rd(p_rd),
    .rn(in_rn),
    .rm(in_rm),
    .imm(p_imm),
    .hw(p_hw),
    .instr(p_instr),
    .err(p_err)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_last <= 1'b0;
      out_error <= 1'b0;
      mask <= '0;
    end else if (expand) begin
      if (out_ready) begin
        out_valid <= mask != '0;
        state <= mask != '0 ? EXPAND : IDLE;
        if (mask != '0) begin
          out_instr <= p_instr;
          out_last <= mask_next == '0;
          mask <= mask_next;
        end
      end
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_instr <= p_instr;
      out_last <= !is_ldi || mask_load == '0;
      out_error <= !is_ldi && p_err;
      mask <= is_ldi ? mask_load : '0;
      state <= is_ldi && mask_load != '0 ? EXPAND : IDLE;
      imm_q <= in_imm[63:16];
      rd_q <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
